dpram_reader: RTL and testbench

DPRAM_READER -- requirements
Module: dpram_reader

---
 rtl/dpram_reader.sv | 155 +++++++++++++++
 tb/tb_dpram_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_reader.sv
// -----------------------------------------------------------------------------
// dpram_reader
//
// Read side of a dual-port RAM ring buffer. The writer publishes a commit
// pointer (wptr_i, MSB = wrap bit). This block prefetches committed words
// from the RAM, keeps them in a two-entry output FIFO and presents them on a
// valid/ready stream. The consumed pointer (rptr_o) only advances on stream
// handshakes, so words that were prefetched but not yet consumed stay
// protected from being overwritten by the writer.
//
// Parameters
//   VECTOR_LENGTH : buffer depth in words (power of two)
//   WORD_WIDTH    : bits per word
//   ADDR_WIDTH    : RAM address width, $clog2(VECTOR_LENGTH)
//
// Ports
//   clk_i        : single clock, also the RAM read clock
//   rst_ni       : asynchronous active-low reset
//   flush_i      : (only with DPRAM_READER_FLUSH_EN) drop everything and
//                  jump both pointers to wptr_i
//   wptr_i       : writer commit pointer, ADDR_WIDTH+1 bits
//   rptr_o       : consumed pointer returned to the writer
//   ram_rclke_o  : RAM read clock enable (same as ram_re_o)
//   ram_re_o     : RAM read enable
//   ram_raddr_o  : RAM read address
//   ram_rdata_i  : RAM read data, valid the cycle after the read strobe
//   data_o       : stream data (FIFO head)
//   valid_o      : stream valid (FIFO non-empty)
//   ready_i      : stream ready
//   empty_o      : high when rptr_o equals wptr_i
//
// Configuration macro: DPRAM_READER_FLUSH_EN adds the flush_i input.
// -----------------------------------------------------------------------------
module dpram_reader #(
  parameter int VECTOR_LENGTH = 512,
  parameter int WORD_WIDTH    = 8,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef DPRAM_READER_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic [ADDR_WIDTH:0]   wptr_i,
  output logic [ADDR_WIDTH:0]   rptr_o,
  output logic                  ram_rclke_o,
  output logic                  ram_re_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [WORD_WIDTH-1:0] ram_rdata_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  empty_o
);

  logic [ADDR_WIDTH:0]   issue_ptr;
  logic [ADDR_WIDTH:0]   rptr_q;
  logic                  in_flight;
  logic [WORD_WIDTH-1:0] fifo_mem [2];
  logic                  wr_idx;
  logic                  rd_idx;
  logic [1:0]            fifo_count;

  logic                  flush;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;

  // Without the flush option the flush term is tied off and folds away.
`ifdef DPRAM_READER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Issue decision. Occupancy counts buffered words plus the word on its way
  // back from the RAM, minus the word leaving this cycle; a new read is only
  // allowed when that total leaves room in the two-entry FIFO. The read
  // strobe is combinational, so it is qualified with rst_ni to keep it low
  // while reset is held even if wptr_i is non-zero.
  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    occupancy = 3'd0;
    issue     = 1'b0;
    pop       = (fifo_count != 2'd0) && ready_i && !flush;
    push      = in_flight && !flush;
    occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
    issue     = rst_ni && !flush && (issue_ptr != wptr_i) && (occupancy < 3'd2);
  end

  // Pointer and in-flight tracking. The issue pointer runs ahead of the
  // consumed pointer by at most two words; flush realigns both to the
  // writer's pointer and cancels the pending RAM capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_ptr <= '0;
      rptr_q    <= '0;
      in_flight <= 1'b0;
    end else if (flush) begin
      issue_ptr <= wptr_i;
      rptr_q    <= wptr_i;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        issue_ptr <= issue_ptr + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Two-entry output FIFO. A push and a pop in the same cycle leave the count
  // unchanged; separate write/read indices keep the word order intact.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      fifo_count  <= 2'd0;
    end else if (flush) begin
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_idx] <= ram_rdata_i;
        wr_idx           <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output assignments. data_o is zeroed whenever the FIFO is empty so no
  // stale word is ever visible on the stream.
  assign valid_o     = (fifo_count != 2'd0);
  assign data_o      = valid_o ? fifo_mem[rd_idx] : '0;
  assign rptr_o      = rptr_q;
  assign empty_o     = (rptr_q == wptr_i);
  assign ram_re_o    = issue;
  assign ram_rclke_o = issue;
  assign ram_raddr_o = issue_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_dpram_reader.sv
// -----------------------------------------------------------------------------
// tb_dpram_reader
//
// Self-checking bench for dpram_reader. A RAM array with a registered read
// port sits behind the DUT; the expected stream is the RAM contents read in
// pointer order, and timing expectations come from the read/latency rules.
// -----------------------------------------------------------------------------
module tb_dpram_reader;

  localparam int VL = 512;
  localparam int W  = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          ram_rclke;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [W-1:0]  ram_rdata;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;
  logic          empty;
`ifdef DPRAM_READER_FLUSH_EN
  logic          flush;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ram_model [VL];

  dpram_reader #(
    .VECTOR_LENGTH(VL),
    .WORD_WIDTH   (W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
`ifdef DPRAM_READER_FLUSH_EN
    .flush_i    (flush),
`endif
    .wptr_i     (wptr),
    .rptr_o     (rptr),
    .ram_rclke_o(ram_rclke),
    .ram_re_o   (ram_re),
    .ram_raddr_o(ram_raddr),
    .ram_rdata_i(ram_rdata),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .empty_o    (empty)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // RAM read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram_model[ram_raddr];
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset;
    rst_n = 1'b0;
    wptr  = '0;
    ready = 1'b0;
`ifdef DPRAM_READER_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_ram_random;
    for (int i = 0; i < VL; i++) ram_model[i] = W'($urandom);
  endtask

  // Reset values, including a non-zero wptr_i while reset is held.
  task automatic test_reset;
    rst_n = 1'b0;
    ready = 1'b1;
    wptr  = 10'd5;
    #3;
    checks++; if (rptr !== 10'd0) begin errors++; $display("[TB] FAIL reset_rptr: got %0h expected 0", rptr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", data); end
    checks++; if (ram_re !== 1'b0 || ram_rclke !== 1'b0) begin errors++; $display("[TB] FAIL reset_re: got re=%0b clke=%0b expected 0/0", ram_re, ram_rclke); end
    checks++; if (ram_raddr !== 9'd0) begin errors++; $display("[TB] FAIL reset_raddr: got %0h expected 0", ram_raddr); end
    checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL reset_empty_ne: got %0b expected 0", empty); end
    wptr = 10'd0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty_eq: got %0b expected 1", empty); end
    do_reset();
  endtask

  // Single word: strobe in cycle 0, valid in cycle 2, rptr after handshake.
  task automatic test_latency;
    do_reset();
    ram_model[0] = 8'hA5;
    @(negedge clk); wptr = 10'd1; #1;
    checks++; if (ram_re !== 1'b1 || ram_raddr !== 9'd0 || ram_rclke !== 1'b1) begin errors++; $display("[TB] FAIL lat_strobe: got re=%0b clke=%0b addr=%0d expected 1/1/0", ram_re, ram_rclke, ram_raddr); end
    @(negedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_cycle1_valid: got %0b expected 0", valid); end
    @(negedge clk); ready = 1'b1; #1;
    checks++; if (valid !== 1'b1 || data !== 8'hA5) begin errors++; $display("[TB] FAIL lat_cycle2: got valid=%0b data=%0h expected 1/a5", valid, data); end
    @(negedge clk); ready = 1'b0; #1;
    checks++; if (rptr !== 10'd1 || empty !== 1'b1 || valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_after: got rptr=%0d empty=%0b valid=%0b expected 1/1/0", rptr, empty, valid); end
  endtask

  // Eight words with ready high: eight consecutive valid cycles.
  task automatic test_burst;
    int got[$];
    int first;
    int last;
    do_reset();
    for (int i = 0; i < 8; i++) ram_model[i] = W'(8'h10 + i);
    ready = 1'b1;
    first = -1;
    last  = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) wptr = 10'd8;
      #1;
      if (valid && ready) begin
        got.push_back(int'(data));
        if (first < 0) first = c;
        last = c;
      end
    end
    checks++; if (got.size() != 8) begin errors++; $display("[TB] FAIL burst_count: got %0d expected 8", got.size()); end
    checks++; if (first != 2 || last - first != 7) begin errors++; $display("[TB] FAIL burst_timing: got first=%0d span=%0d expected 2/7", first, last - first); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] != 16 + i) begin errors++; $display("[TB] FAIL burst_data[%0d]: got %0h expected %0h", i, got[i], 16 + i); end
    end
    checks++; if (rptr !== 10'd8 || empty !== 1'b1) begin errors++; $display("[TB] FAIL burst_end: got rptr=%0d empty=%0b expected 8/1", rptr, empty); end
    ready = 1'b0;
  endtask

  // Back-pressure: only two reads outstanding, then lossless resume.
  task automatic test_backpressure;
    int reads;
    int got[$];
    do_reset();
    for (int i = 0; i < 8; i++) ram_model[i] = W'(8'h10 + i);
    reads = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) wptr = 10'd8;
      #1;
      if (ram_re) reads++;
    end
    checks++; if (reads != 2) begin errors++; $display("[TB] FAIL bp_reads: got %0d expected 2", reads); end
    checks++; if (valid !== 1'b1 || data !== 8'h10 || rptr !== 10'd0) begin errors++; $display("[TB] FAIL bp_hold: got valid=%0b data=%0h rptr=%0d expected 1/10/0", valid, data, rptr); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ready = 1'b1;
      #1;
      if (valid && ready) got.push_back(int'(data));
    end
    checks++; if (got.size() != 8) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] != 16 + i) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %0h expected %0h", i, got[i], 16 + i); end
    end
    checks++; if (rptr !== 10'd8) begin errors++; $display("[TB] FAIL bp_rptr: got %0d expected 8", rptr); end
    ready = 1'b0;
  endtask

  // Address wrap: 510, 511, 0, 1 with the wrap bit set afterwards.
  task automatic test_wrap;
    int addrs[$];
    int got[$];
    bit reached;
    do_reset();
    fill_ram_random();
    ready = 1'b1;
    reached = 1'b0;
    @(negedge clk); wptr = 10'd510;
    for (int c = 0; c < 700 && !reached; c++) begin
      @(negedge clk); #1;
      if (rptr == 10'd510) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("[TB] FAIL wrap_drain_timeout: got rptr=%0d expected 510", rptr); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) wptr = 10'h202;
      #1;
      if (ram_re) addrs.push_back(int'(ram_raddr));
      if (valid && ready) got.push_back(int'(data));
    end
    checks++; if (addrs.size() != 4) begin errors++; $display("[TB] FAIL wrap_nreads: got %0d expected 4", addrs.size()); end
    for (int i = 0; i < addrs.size() && i < 4; i++) begin
      checks++; if (addrs[i] != (510 + i) % VL) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, addrs[i], (510 + i) % VL); end
    end
    checks++; if (got.size() != 4) begin errors++; $display("[TB] FAIL wrap_nwords: got %0d expected 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] != int'(ram_model[(510 + i) % VL])) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %0h expected %0h", i, got[i], ram_model[(510 + i) % VL]); end
    end
    checks++; if (rptr !== 10'h202 || empty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_rptr: got rptr=%0h empty=%0b expected 202/1", rptr, empty); end
    ready = 1'b0;
  endtask

  // Reset in the middle of a stream discards buffered words.
  task automatic test_reset_midstream;
    int got[$];
    do_reset();
    fill_ram_random();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) wptr = 10'd8;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || data !== 8'h00 || rptr !== 10'd0) begin errors++; $display("[TB] FAIL midrst_async: got valid=%0b data=%0h rptr=%0d expected 0/0/0", valid, data, rptr); end
    checks++; if (ram_re !== 1'b0 || ram_raddr !== 9'd0) begin errors++; $display("[TB] FAIL midrst_ram: got re=%0b addr=%0d expected 0/0", ram_re, ram_raddr); end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || ram_re !== 1'b1 || ram_raddr !== 9'd0) begin errors++; $display("[TB] FAIL midrst_first: got valid=%0b re=%0b addr=%0d expected 0/1/0", valid, ram_re, ram_raddr); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (valid && ready) got.push_back(int'(data));
    end
    checks++; if (got.size() != 8) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] != int'(ram_model[i])) begin errors++; $display("[TB] FAIL midrst_data[%0d]: got %0h expected %0h", i, got[i], ram_model[i]); end
    end
    ready = 1'b0;
  endtask

`ifdef DPRAM_READER_FLUSH_EN
  // Flush with words buffered and a read in flight.
  task automatic test_flush;
    int got[$];
    do_reset();
    fill_ram_random();
    ram_model[8] = 8'h5A;
    @(negedge clk); wptr = 10'd8;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (ram_re !== 1'b0) begin errors++; $display("[TB] FAIL flush_noissue: got %0b expected 0", ram_re); end
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (valid !== 1'b0 || rptr !== 10'd8 || empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_after: got valid=%0b rptr=%0d empty=%0b expected 0/8/1", valid, rptr, empty); end
    ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) wptr = 10'd9;
      #1;
      if (valid && ready) got.push_back(int'(data));
    end
    checks++; if (got.size() != 1 || (got.size() == 1 && got[0] != 8'h5A)) begin errors++; $display("[TB] FAIL flush_stream: got %0d words expected 1 word 5a", got.size()); end
    checks++; if (rptr !== 10'd9) begin errors++; $display("[TB] FAIL flush_rptr: got %0d expected 9", rptr); end
    ready = 1'b0;
  endtask
`endif

  // Random writer advances and random ready against a pointer-level model:
  // each read issued in cycle k becomes visible in cycle k+2, at most two
  // words are outstanding, and the stream is the RAM in pointer order.
  task automatic test_random;
    int w;
    int rptr_m;
    int issued;
    int issue_cyc[$];
    bit valid_exp;
    bit pop_exp;
    bit re_exp;
    int room;
    do_reset();
    fill_ram_random();
    w = 0;
    rptr_m = 0;
    issued = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      room = VL - (w - rptr_m);
      if (room > 0 && $urandom_range(0, 2) == 0) w += $urandom_range(1, (room < 4) ? room : 4);
      wptr  = 10'(w);
      ready = ($urandom_range(0, 3) != 0);
      #1;
      valid_exp = (issue_cyc.size() > 0) && (issue_cyc[0] <= c - 2);
      pop_exp   = valid_exp && ready;
      re_exp    = (issued != w) && ((issued - rptr_m - int'(pop_exp)) < 2);
      checks++; if (valid !== valid_exp) begin errors++; $display("[TB] FAIL rnd_valid c=%0d: got %0b expected %0b", c, valid, valid_exp); end
      checks++; if (ram_re !== re_exp || ram_rclke !== re_exp) begin errors++; $display("[TB] FAIL rnd_re c=%0d: got re=%0b clke=%0b expected %0b", c, ram_re, ram_rclke, re_exp); end
      checks++; if (rptr !== 10'(rptr_m)) begin errors++; $display("[TB] FAIL rnd_rptr c=%0d: got %0h expected %0h", c, rptr, 10'(rptr_m)); end
      checks++; if (empty !== (rptr_m == w)) begin errors++; $display("[TB] FAIL rnd_empty c=%0d: got %0b expected %0b", c, empty, (rptr_m == w)); end
      if (pop_exp) begin
        checks++; if (data !== ram_model[rptr_m % VL]) begin errors++; $display("[TB] FAIL rnd_data c=%0d: got %0h expected %0h", c, data, ram_model[rptr_m % VL]); end
        void'(issue_cyc.pop_front());
        rptr_m++;
      end
      if (re_exp) begin
        checks++; if (ram_raddr !== 9'(issued)) begin errors++; $display("[TB] FAIL rnd_addr c=%0d: got %0d expected %0d", c, ram_raddr, issued % VL); end
        issue_cyc.push_back(c);
        issued++;
      end
    end
    ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wptr  = '0;
    ready = 1'b0;
`ifdef DPRAM_READER_FLUSH_EN
    flush = 1'b0;
`endif
    $display("[TB] starting dpram_reader bench");
    test_reset();
    test_latency();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_midstream();
`ifdef DPRAM_READER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
